// File: rtl/freeze_key_decoder_if.sv
// Keyboard-side bundle for freeze_key_decoder: scancode byte stream and enable
// in, freeze request and Ctrl status out.
interface freeze_key_decoder_if;
  logic       kbd_strobe;
  logic [7:0] kbd_data;
  logic       enable;
  logic       freeze;
  logic       ctrl_down;

  modport master (
    output kbd_strobe,
    output kbd_data,
    output enable,
    input  freeze,
    input  ctrl_down
  );

  modport slave (
    input  kbd_strobe,
    input  kbd_data,
    input  enable,
    output freeze,
    output ctrl_down
  );
endinterface

// File: rtl/freeze_key_decoder.sv
// PS/2 set-2 Ctrl+Break detector producing a fixed-width, locked-out freeze pulse.
// Optional macro FREEZE_PAUSE_EN: the full Pause sequence also fires freeze.
module freeze_key_decoder #(
  parameter int PULSE_LEN      = 16,
  parameter int PREFIX_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  freeze_key_decoder_if.slave  kbd
);

  localparam int TMO_W = (PREFIX_TIMEOUT < 2) ? 1 : $clog2(PREFIX_TIMEOUT + 1);

  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_REL   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_BREAK = 8'h7E;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXT    = 3'd1,
    S_REL    = 3'd2,
    S_EXTREL = 3'd3,
    S_PAUSE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [2:0]       e1_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [7:0]       pulse_cnt_r;
  logic             ctrl_l_r;
  logic             ctrl_r_r;
  logic             brk_down_r;
  logic             freeze_r;
  logic             ctrl_down_r;

  logic             ctrl_l_s;
  logic             ctrl_r_s;
  logic             brk_make_s;
  logic             brk_rel_s;
  logic             pause_fire_s;
  logic             trig_s;

  // Decode key events from the current prefix state and the strobed byte.
  always_comb begin
    ctrl_l_s   = ctrl_l_r;
    ctrl_r_s   = ctrl_r_r;
    brk_make_s = 1'b0;
    brk_rel_s  = 1'b0;
    if (kbd.kbd_strobe) begin
      case (state_r)
        S_IDLE: begin
          if (kbd.kbd_data == SC_CTRL) begin
            ctrl_l_s = 1'b1;
          end else begin
            ctrl_l_s = ctrl_l_r;
          end
        end
        S_EXT: begin
          if (kbd.kbd_data == SC_CTRL) begin
            ctrl_r_s = 1'b1;
          end else if (kbd.kbd_data == SC_BREAK) begin
            brk_make_s = 1'b1;
          end else begin
            brk_make_s = 1'b0;
          end
        end
        S_REL: begin
          if (kbd.kbd_data == SC_CTRL) begin
            ctrl_l_s = 1'b0;
          end else begin
            ctrl_l_s = ctrl_l_r;
          end
        end
        S_EXTREL: begin
          if (kbd.kbd_data == SC_CTRL) begin
            ctrl_r_s = 1'b0;
          end else if (kbd.kbd_data == SC_BREAK) begin
            brk_rel_s = 1'b1;
          end else begin
            brk_rel_s = 1'b0;
          end
        end
        // Pause bytes are swallowed, so Ctrl tracking must not see them.
        S_PAUSE: begin
          ctrl_l_s = ctrl_l_r;
          ctrl_r_s = ctrl_r_r;
        end
        default: begin
          ctrl_l_s = ctrl_l_r;
          ctrl_r_s = ctrl_r_r;
        end
      endcase
    end else begin
      ctrl_l_s = ctrl_l_r;
      ctrl_r_s = ctrl_r_r;
    end
  end

`ifdef FREEZE_PAUSE_EN
  function automatic logic [7:0] pause_byte(input logic [2:0] idx);
    case (idx)
      3'd7:    return 8'h14;
      3'd6:    return 8'h77;
      3'd5:    return 8'hE1;
      3'd4:    return 8'hF0;
      3'd3:    return 8'h14;
      3'd2:    return 8'hF0;
      3'd1:    return 8'h77;
      default: return 8'h00;
    endcase
  endfunction

  logic pause_ok_r;

  // Remember whether every byte swallowed so far matched the canonical Pause stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_ok_r <= 1'b0;
    end else if (kbd.kbd_strobe && (state_r == S_IDLE) && (kbd.kbd_data == SC_PAUSE)) begin
      pause_ok_r <= 1'b1;
    end else if (kbd.kbd_strobe && (state_r == S_PAUSE)) begin
      pause_ok_r <= pause_ok_r && (kbd.kbd_data == pause_byte(e1_cnt_r));
    end else begin
      pause_ok_r <= pause_ok_r;
    end
  end

  // The last Pause byte completes the sequence only if everything before it matched.
  always_comb begin
    pause_fire_s = kbd.kbd_strobe && (state_r == S_PAUSE) && (e1_cnt_r == 3'd1) &&
                   pause_ok_r && (kbd.kbd_data == pause_byte(3'd1));
  end
`else
  assign pause_fire_s = 1'b0;
`endif

  // A new pulse needs enable and an idle pulse counter; Break also needs Ctrl and a released key.
  always_comb begin
    trig_s = kbd.enable && (pulse_cnt_r == 8'd0) &&
             ((brk_make_s && ctrl_down_r && !brk_down_r) || pause_fire_s);
  end

  // Prefix FSM: advances on strobes, falls back to IDLE after a silent prefix timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      e1_cnt_r  <= 3'd0;
      tmo_cnt_r <= '0;
    end else if (kbd.kbd_strobe) begin
      tmo_cnt_r <= '0;
      case (state_r)
        S_IDLE: begin
          case (kbd.kbd_data)
            SC_EXT:   state_r <= S_EXT;
            SC_REL:   state_r <= S_REL;
            SC_PAUSE: begin
              state_r  <= S_PAUSE;
              e1_cnt_r <= 3'd7;
            end
            default:  state_r <= S_IDLE;
          endcase
        end
        S_EXT: begin
          if (kbd.kbd_data == SC_REL) begin
            state_r <= S_EXTREL;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_REL:    state_r <= S_IDLE;
        S_EXTREL: state_r <= S_IDLE;
        S_PAUSE: begin
          e1_cnt_r <= e1_cnt_r - 3'd1;
          if (e1_cnt_r == 3'd1) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= S_PAUSE;
          end
        end
        default:  state_r <= S_IDLE;
      endcase
    end else if (state_r != S_IDLE) begin
      if (tmo_cnt_r == TMO_W'(PREFIX_TIMEOUT - 1)) begin
        state_r   <= S_IDLE;
        tmo_cnt_r <= '0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  // Key-held state; Break make/release run regardless of enable so lockout survives disable.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_l_r    <= 1'b0;
      ctrl_r_r    <= 1'b0;
      ctrl_down_r <= 1'b0;
      brk_down_r  <= 1'b0;
    end else begin
      ctrl_l_r    <= ctrl_l_s;
      ctrl_r_r    <= ctrl_r_s;
      ctrl_down_r <= ctrl_l_s | ctrl_r_s;
      if (brk_make_s) begin
        brk_down_r <= 1'b1;
      end else if (brk_rel_s) begin
        brk_down_r <= 1'b0;
      end else begin
        brk_down_r <= brk_down_r;
      end
    end
  end

  // Pulse generator: triggers arriving while the counter runs are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_cnt_r <= 8'd0;
      freeze_r    <= 1'b0;
    end else if (!kbd.enable) begin
      pulse_cnt_r <= 8'd0;
      freeze_r    <= 1'b0;
    end else if (trig_s) begin
      pulse_cnt_r <= 8'(PULSE_LEN);
      freeze_r    <= 1'b1;
    end else if (pulse_cnt_r != 8'd0) begin
      pulse_cnt_r <= pulse_cnt_r - 8'd1;
      freeze_r    <= (pulse_cnt_r > 8'd1);
    end else begin
      pulse_cnt_r <= 8'd0;
      freeze_r    <= 1'b0;
    end
  end

  assign kbd.freeze    = freeze_r;
  assign kbd.ctrl_down = ctrl_down_r;

endmodule

// File: tb/tb_freeze_key_decoder.sv
// Scoreboard bench for freeze_key_decoder: stimulus queues expected freeze pulses,
// a negedge monitor measures each observed pulse and compares against the queue.
module tb_freeze_key_decoder;

  localparam int PLEN = 16;
  localparam int TMO  = 40;

  typedef struct {
    int start;
    int len;
  } pulse_t;

  logic clk;
  logic reset;
  int   cyc;
  int   last_cyc;
  int   n_pass;
  int   n_total;
  pulse_t exp_q[$];

  logic prev_f;
  int   run_start;
  int   run_len;

  freeze_key_decoder_if kif();

  freeze_key_decoder #(.PULSE_LEN(PLEN), .PREFIX_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .kbd   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total = n_total + 1;
    if (act == exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: measure each freeze pulse and compare against the scoreboard.
  always @(negedge clk) begin
    pulse_t e;
    if (kif.freeze === 1'b1 && !prev_f) begin
      run_start = cyc;
      run_len   = 1;
    end else if (kif.freeze === 1'b1) begin
      run_len = run_len + 1;
    end else if (prev_f) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_start", run_start, -1);
      end else begin
        e = exp_q.pop_front();
        check("pulse_start", run_start, e.start);
        check("pulse_len", run_len, e.len);
      end
    end
    prev_f = (kif.freeze === 1'b1);
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    kif.kbd_strobe = 1'b1;
    kif.kbd_data   = b;
    last_cyc       = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      kif.kbd_strobe = 1'b0;
    end
  endtask

  task automatic expect_pulse(input int len);
    pulse_t p;
    p.start = last_cyc + 1;
    p.len   = len;
    exp_q.push_back(p);
  endtask

  task automatic chk_ctrl(input string name, input int exp);
    @(negedge clk);
    check(name, int'(kif.ctrl_down), exp);
  endtask

  task automatic settle(input string name);
    idle(24);
    check(name, exp_q.size(), 0);
  endtask

  task automatic brk_make();
    send(8'hE0);
    send(8'h7E);
  endtask

  task automatic brk_rel();
    send(8'hE0);
    send(8'hF0);
    send(8'h7E);
  endtask

  task automatic pause_seq();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    cyc            = 0;
    last_cyc       = 0;
    prev_f         = 1'b0;
    run_start      = 0;
    run_len        = 0;
    reset          = 1'b1;
    kif.kbd_strobe = 1'b0;
    kif.kbd_data   = 8'h00;
    kif.enable     = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("reset_freeze", int'(kif.freeze), 0);
    check("reset_ctrl_down", int'(kif.ctrl_down), 0);

    // Ctrl+Break, back-to-back strobes
    send(8'h14); brk_make(); expect_pulse(PLEN);
    idle(1);
    chk_ctrl("cb_ctrl_down", 1);
    settle("cb_queue");
    brk_rel(); send(8'hF0); send(8'h14); idle(1);
    chk_ctrl("cb_ctrl_release", 0);

    // Typematic repeats and pulse-time lockout
    send(8'h14); idle(1); brk_make(); expect_pulse(PLEN);
    idle(20); brk_make();
    idle(20); brk_make();
    idle(20); brk_rel(); idle(2); brk_make(); expect_pulse(PLEN);
    brk_rel(); brk_make();
    idle(20); brk_make();
    settle("typematic_queue");
    brk_rel(); send(8'hF0); send(8'h14);

    // No Ctrl, Ctrl released, then right Ctrl
    idle(2); brk_make(); idle(20); brk_rel();
    send(8'h14); send(8'hF0); send(8'h14); brk_make(); idle(20); brk_rel();
    settle("noctrl_queue");
    send(8'hE0); send(8'h14); idle(1);
    chk_ctrl("rctrl_down", 1);
    brk_make(); expect_pulse(PLEN);
    settle("rctrl_queue");
    send(8'hE0); send(8'hF0); send(8'h14); idle(1);
    chk_ctrl("rctrl_release", 0);
    brk_rel();

    // Pause stream, with and without Ctrl held
    idle(2); pause_seq();
`ifdef FREEZE_PAUSE_EN
    expect_pulse(PLEN);
`endif
    idle(1);
    chk_ctrl("pause_no_ctrl", 0);
    settle("pause_queue");
    send(8'h14); idle(1); pause_seq();
`ifdef FREEZE_PAUSE_EN
    expect_pulse(PLEN);
`endif
    idle(1);
    chk_ctrl("pause_ctrl_iso", 1);
    settle("pause_iso_queue");
    send(8'hF0); send(8'h14); idle(1);
    chk_ctrl("pause_ctrl_release", 0);

    // enable low: tracking continues, Break stays locked out until released
    kif.enable = 1'b0;
    send(8'h14); brk_make(); idle(20);
    chk_ctrl("dis_ctrl_down", 1);
    kif.enable = 1'b1;
    idle(2); brk_make(); idle(20);
    brk_rel(); brk_make(); expect_pulse(PLEN);
    settle("enable_queue");
    // enable dropped in pulse cycle 3 truncates the pulse
    brk_rel(); idle(2); brk_make(); expect_pulse(3);
    idle(3); kif.enable = 1'b0;
    idle(2); kif.enable = 1'b1;
    settle("enable_drop_queue");
    brk_rel(); send(8'hF0); send(8'h14);

    // Prefix timeout boundary
    send(8'h14); idle(1);
    send(8'hE0); idle(TMO); send(8'h7E);
    settle("tmo_expired_queue");
    send(8'hE0); idle(TMO - 1); send(8'h7E); expect_pulse(PLEN);
    settle("tmo_edge_queue");
    brk_rel(); send(8'hF0); send(8'h14);

    // Reset in pulse cycle 5
    send(8'h14); brk_make(); expect_pulse(5);
    idle(5); reset = 1'b1;
    idle(1); reset = 1'b0;
    chk_ctrl("reset_mid_ctrl", 0);
    check("reset_mid_freeze", int'(kif.freeze), 0);
    settle("reset_queue");
    // After reset brk_down is clear, but Ctrl must be pressed again
    brk_make(); idle(20);
    send(8'h14); brk_rel(); brk_make(); expect_pulse(PLEN);
    settle("post_reset_queue");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
